// File: rtl/y_alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB on one shared adder, with a combinational signed-overflow flag and a sticky copy of it.
// Optional signed set-less-than on op 3'b111 when YALU_SLT_EN is defined.
module y_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex,
  output logic             ex_sticky
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
`ifdef YALU_SLT_EN
  localparam logic [2:0] OP_SLT = 3'b111;
`endif

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  // SLT reuses the subtractor, so both codes select the inverted-b path.
`ifdef YALU_SLT_EN
  assign is_sub = (op == OP_SUB) || (op == OP_SLT);
`else
  assign is_sub = (op == OP_SUB);
`endif

  // Single shared adder; subtract is a + ~b + 1.
  assign b_eff = is_sub ? ~b : b;
  assign sum   = a + b_eff + WIDTH'(is_sub);

  // Signed overflow: addends share a sign that the result does not.
  assign ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);

`ifdef YALU_SLT_EN
  logic lt;
  // Sign XOR overflow gives the true signed ordering even when a - b overflows.
  assign lt = sum[MSB] ^ ovf;
`endif

  // Result and exception select; unused codes give zero.
  always_comb begin
    z  = '0;
    ex = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: begin
        z  = sum;
        ex = ovf;
      end
      OP_SUB: begin
        z  = sum;
        ex = ovf;
      end
`ifdef YALU_SLT_EN
      OP_SLT: z = WIDTH'(lt);
`endif
      default: begin
        z  = '0;
        ex = 1'b0;
      end
    endcase
  end

  // Sticky overflow record; reset wins over a coincident overflow.
  always_ff @(posedge clk) begin
    if (rst) ex_sticky <= 1'b0;
    else     ex_sticky <= ex_sticky | ex;
  end

endmodule

// File: tb/tb_y_alu.sv
// Self-checking bench for y_alu: directed boundary cases, sticky/reset sequence and random ops against an arithmetic model.
module tb_y_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] z;
  logic        ex;
  logic        ex_sticky;

  int checks;
  int errors;

  y_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .z         (z),
    .ex        (ex),
    .ex_sticky (ex_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed results in 64-bit, overflow when outside the 32-bit signed range.
  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mop);
    longint sa;
    longint sb;
    longint r;
    logic [31:0] rz;
    logic        rex;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    rz  = 32'h0;
    rex = 1'b0;
    case (mop)
      3'b000: rz = ma & mb;
      3'b001: rz = ma | mb;
      3'b010: begin
        r   = sa + sb;
        rz  = r[31:0];
        rex = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        r   = sa - sb;
        rz  = r[31:0];
        rex = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
`ifdef YALU_SLT_EN
      3'b111: rz = (sa < sb) ? 32'h1 : 32'h0;
`endif
      default: rz = 32'h0;
    endcase
    return {rex, rz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply operands, settle, compare z/ex against fixed expectations.
  task automatic dir(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [2:0] top, input logic [31:0] ez, input logic eex);
    a  = ta;
    b  = tb_;
    op = top;
    #1;
    chk({tag, "_z"}, z, ez);
    chk({tag, "_ex"}, 32'(ex), 32'(eex));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] m;
    logic [2:0]  ops4 [4];
    checks = 0;
    errors = 0;
    ops4[0] = 3'b000; ops4[1] = 3'b001; ops4[2] = 3'b010; ops4[3] = 3'b110;
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    op  = 3'b000;

    @(negedge clk);
    cyc();
    chk("reset_sticky", 32'(ex_sticky), 32'h0);
    rst = 1'b0;

    dir("and",       32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0);
    dir("or",        32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0);
    dir("add_small", 32'h5,        32'h7,        3'b010, 32'hC,        1'b0);
    dir("add_ovf",   32'h7FFFFFFF, 32'h1,        3'b010, 32'h80000000, 1'b1);
    dir("add_wrap",  32'hFFFFFFFF, 32'h1,        3'b010, 32'h0,        1'b0);
    dir("sub_neg",   32'h5,        32'h7,        3'b110, 32'hFFFFFFFE, 1'b0);
    dir("sub_ovf",   32'h80000000, 32'h1,        3'b110, 32'h7FFFFFFF, 1'b1);
    dir("sub_minneg",32'h0,        32'h80000000, 3'b110, 32'h80000000, 1'b1);
    dir("sub_self",  32'h12345678, 32'h12345678, 3'b110, 32'h0,        1'b0);
    dir("add_negovf",32'h80000000, 32'h80000000, 3'b010, 32'h0,        1'b1);

    for (int i = 0; i < 3; i++) begin
      logic [2:0] uop;
      uop = 3'(3 + i);
      dir("unused", $urandom, $urandom, uop, 32'h0, 1'b0);
    end
`ifdef YALU_SLT_EN
    dir("slt_neg1", 32'hFFFFFFFF, 32'h0, 3'b111, 32'h1, 1'b0);
    dir("slt_gt",   32'h3,        32'h2, 3'b111, 32'h0, 1'b0);
    dir("slt_ovf",  32'h80000000, 32'h1, 3'b111, 32'h1, 1'b0);
    dir("slt_ovf2", 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h0, 1'b0);
`else
    dir("op111", 32'hFFFFFFFF, 32'h0, 3'b111, 32'h0, 1'b0);
`endif

    // Sticky sequence: clear, set by one overflow, hold, then reset beats overflow.
    @(negedge clk);
    rst = 1'b1; a = 32'h1; b = 32'h1; op = 3'b010;
    cyc();
    chk("sticky_rst", 32'(ex_sticky), 32'h0);
    rst = 1'b0;
    cyc();
    chk("sticky_noovf", 32'(ex_sticky), 32'h0);
    a = 32'h7FFFFFFF; b = 32'h1; op = 3'b010;
    cyc();
    chk("sticky_set", 32'(ex_sticky), 32'h1);
    for (int i = 0; i < 5; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = (i % 2 == 0) ? 3'b000 : 3'b001;
      cyc();
      chk("sticky_hold", 32'(ex_sticky), 32'h1);
    end
    a = 32'h7FFFFFFF; b = 32'h1; op = 3'b010; rst = 1'b1;
    #1;
    chk("ovf_during_rst", 32'(ex), 32'h1);
    cyc();
    chk("sticky_rst_prio", 32'(ex_sticky), 32'h0);
    rst = 1'b0; op = 3'b000;
    cyc();
    chk("sticky_after_rst", 32'(ex_sticky), 32'h0);

    // Randomized ops against the model; bias some operands toward extremes.
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      b  = $urandom;
      if (i % 8 == 1) a = {a[31], {31{~a[31]}}};
      if (i % 8 == 2) b = {b[31], {31{~b[31]}}};
      op = ops4[$urandom_range(0, 3)];
      #1;
      m = model(a, b, op);
      chk("rand_z", z, m[31:0]);
      chk("rand_ex", 32'(ex), 32'(m[32]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
